fp_addsub_pipe: RTL and testbench
=================================

FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

Interface
REQ-001 The block SHALL take parameter EXP_W, default 4, meaning the exponent field width; legal range 3..8.
REQ-002 The block SHALL take parameter MAN_W, default 4, meaning the stored fraction width with an implicit leading 1; legal range 3..23.
REQ-003 The block SHALL use derived constants W = 1+EXP_W+MAN_W and BIAS = 2^(EXP_W-1)-1; operand format is {sign, exp, fract}.
REQ-004 clk50M  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-low.
REQ-006 in_valid  input  1  operand pair and op are valid this cycle.
REQ-007 in_ready  output  1  block accepts the pair this cycle.
REQ-008 a, b  input  W each  operands.
REQ-009 sub  input  1  1 means compute a-b, 0 means compute a+b.
REQ-010 out_valid  output  1  result is valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 sum  output  W  result.
REQ-013 overflow, underflow, zero, inexact  output  1 each  result flags, qualified by out_valid.

Function
REQ-014 A transfer SHALL occur on a cycle with valid&&ready on the respective side; data and flags SHALL be held stable while out_valid=1 and out_ready=0.
REQ-015 The pipeline SHALL have 3 stages: S1 unpack, compare and align; S2 add or subtract; S3 normalise, round and pack. Latency is exactly 3 cycles from input transfer to out_valid with no stall.
REQ-016 Each stage SHALL advance when the next stage is empty or advancing; in_ready = !S1_valid || S1_advances. Throughput is 1 per cycle; no bubble is inserted under continuous out_ready=1.
REQ-017 Effective sign of b SHALL be b.sign^sub; effective operation is subtract when the effective signs differ.
REQ-018 exp=0 SHALL denote zero whatever the fraction (no denormals, no Inf/NaN); exp=2^EXP_W-1 is an ordinary normal exponent.
REQ-019 S1 SHALL swap so the larger magnitude is first, compared on {exp,fract}; on equal magnitude a is taken as larger. The result sign is the sign of the larger operand.
REQ-020 The smaller significand SHALL be right-shifted by the exponent difference into MAN_W+1 bits plus guard, round and sticky bits; shifted-out ones OR into sticky. A difference >= MAN_W+3 leaves only sticky (set if nonzero).
REQ-021 S2 SHALL use an adder of MAN_W+5 bits, keeping the carry-out.
REQ-022 S3 normalisation SHALL work as follows: on carry-out, shift right by 1 and increment the exponent; otherwise shift left by the leading-zero count and subtract that count from the exponent.
REQ-023 Rounding SHALL be round-to-nearest-even on guard, round and sticky; a rounding carry renormalises and increments the exponent. inexact = guard|round|sticky before rounding.
REQ-024 If the final exponent exceeds 2^EXP_W-1, the result SHALL saturate to {sign, all-ones exp, all-ones fract} with overflow=1.
REQ-025 If the final exponent is < 1, the result SHALL flush to +0 with underflow=1, zero=1 and inexact=1.
REQ-026 Exact cancellation SHALL return +0 (all bits 0) with zero=1 and other flags 0.
REQ-027 A zero operand SHALL pass the other operand through unchanged (effective sign applied); 0±0 SHALL give +0 with zero=1.

Reset
REQ-028 While rst=0, all stage valid bits, out_valid, sum and flags SHALL be 0 and in_ready SHALL be 0; in-flight operations are discarded.
REQ-029 in_ready SHALL be 1 in the first cycle after rst deasserts; reset mid-operation loses all in-flight data with no partial output.

Structure
REQ-030 Package fp_pkg SHALL hold the BIAS and W helper functions, the stage payload struct typedefs and the flag struct {overflow, underflow, zero, inexact}.
REQ-031 One sub-module fp_lzc SHALL exist: a parametrised leading-zero counter of width MAN_W+5 used by S3.

Verification (EXP_W=4, MAN_W=4, BIAS=7)
REQ-032 a=9'h078, b=9'h078, sub=0 -> sum=9'h088 (3.0) 3 cycles later, all flags 0.
REQ-033 a=9'h078, b=9'h078, sub=1 -> sum=9'h000, zero=1.
REQ-034 Ties: 9'h070+9'h020 -> 9'h070, inexact=1; 9'h071+9'h020 -> 9'h072, inexact=1.
REQ-035 Range limits: 9'h0FF+9'h0FF -> 9'h0FF with overflow=1; 9'h011 sub 9'h010 -> 9'h000 with underflow=1 and zero=1.
REQ-036 Backpressure: with out_ready=0, feed 5 back-to-back pairs -> in_ready drops after 3 accepts. Raising out_ready then yields the 3 results in order, each held stable while stalled, and the next pair is accepted.
REQ-037 Reset: assert rst for 1 cycle with 2 operations in flight -> out_valid=0 immediately, no stale result appears afterwards, and in_ready=1 on the next cycle.

Source files
------------

// File: rtl/fp_pkg.sv
// fp_pkg: shared helpers, stage payload and flag types for the fp add/sub pipeline
package fp_pkg;
  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction
  function automatic int fp_width(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction
  typedef struct packed {
    logic overflow;
    logic underflow;
    logic zero;
    logic inexact;
  } flags_t;
  typedef struct packed {
    logic       sign;
    logic [9:0] exp;
  } s2_t;
  typedef struct packed {
    logic eff_sub;
    s2_t  hdr;
  } s1_t;
endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: leading-zero counter, returns N for an all-zero input
module fp_lzc #(
  parameter int N = 9,
  localparam int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  d,
  output logic [CW-1:0] cnt
);
  always_comb begin
    cnt = CW'(N);
    for (int i = 0; i < N; i++) if (d[i]) cnt = CW'(N - 1 - i);
  end
endmodule

// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: 3-stage valid/ready floating-point adder/subtractor with RNE rounding
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 4,
  parameter int MAN_W = 4,
  localparam int W = fp_width(EXP_W, MAN_W)
) (
  input  logic         clk50M,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         overflow,
  output logic         underflow,
  output logic         zero,
  output logic         inexact
);
  localparam int AW = MAN_W + 4;
  localparam int N = MAN_W + 5;
  localparam int CW = $clog2(N + 1);
  localparam int RW = MAN_W + 2;
  localparam logic signed [9:0] EMAX = 10'((1 << EXP_W) - 1);
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;
  logic [AW-1:0] big_q, big_d, sml_q, sml_d;
  logic [N-1:0] r_q, r_d;
  logic [W-1:0] sum_q, sum_d;
  flags_t fl_q, fl_d;
  logic en1, en2, en3;
  logic sb, swap;
  logic [EXP_W-1:0] be, se, diff;
  logic [MAN_W-1:0] bf, sf;
  logic [AW-1:0] ext, nrm;
  logic [CW-1:0] lz;
  logic rup, inx;
  logic [RW-1:0] rnd;
  logic signed [9:0] e_f;
  assign en3 = !v3_q || out_ready;
  assign en2 = !v2_q || en3;
  assign en1 = !v1_q || en2;
  assign in_ready = rst && en1;
  assign out_valid = v3_q;
  assign sum = sum_q;
  assign {overflow, underflow, zero, inexact} = fl_q;
  always_comb begin
    sb = b[W-1] ^ sub;
    swap = b[W-2:0] > a[W-2:0];
    be = swap ? b[W-2:MAN_W] : a[W-2:MAN_W];
    se = swap ? a[W-2:MAN_W] : b[W-2:MAN_W];
    bf = swap ? b[MAN_W-1:0] : a[MAN_W-1:0];
    sf = swap ? a[MAN_W-1:0] : b[MAN_W-1:0];
    diff = be - se;
    ext = {1'b1, sf, 3'b000};
    v1_d = en1 ? in_valid : v1_q;
    s1_d = en1 ? s1_t'{eff_sub: a[W-1] ^ sb, hdr: s2_t'{sign: swap ? sb : a[W-1], exp: 10'(be)}} : s1_q;
    big_d = en1 ? (be == '0 ? AW'(0) : {1'b1, bf, 3'b000}) : big_q;
    sml_d = en1 ? (se == '0 ? AW'(0) : int'(diff) >= MAN_W + 3 ? AW'(1) :
                   (ext >> diff) | AW'(|(ext & ((AW'(1) << diff) - AW'(1))))) : sml_q;
  end
  always_comb begin
    v2_d = en2 ? v1_q : v2_q;
    s2_d = en2 ? s1_q.hdr : s2_q;
    r_d = en2 ? (s1_q.eff_sub ? {1'b0, big_q} - {1'b0, sml_q} : {1'b0, big_q} + {1'b0, sml_q}) : r_q;
  end
  fp_lzc #(.N(N)) u_lzc (.d(r_q), .cnt(lz));
  always_comb begin
    nrm = r_q[N-1] ? {r_q[N-1:2], r_q[1] | r_q[0]} : AW'(r_q << (lz - CW'(1)));
    rup = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
    inx = |nrm[2:0];
    rnd = {1'b0, nrm[AW-1:3]} + RW'(rup);
    e_f = $signed(s2_q.exp) + (r_q[N-1] ? 10'sd1 : 10'sd1 - $signed(10'(lz))) + $signed(10'(rnd[RW-1]));
    v3_d = en3 ? v2_q : v3_q;
    sum_d = en3 ? (r_q == '0 ? W'(0) :
                   e_f > EMAX ? {s2_q.sign, {(W-1){1'b1}}} :
                   e_f < 10'sd1 ? W'(0) :
                   {s2_q.sign, e_f[EXP_W-1:0], rnd[RW-1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0]}) : sum_q;
    fl_d = en3 ? (r_q == '0 ? flags_t'(4'b0010) :
                  e_f > EMAX ? flags_t'{1'b1, 1'b0, 1'b0, inx} :
                  e_f < 10'sd1 ? flags_t'(4'b0111) :
                  flags_t'{1'b0, 1'b0, 1'b0, inx}) : fl_q;
  end
  always_ff @(posedge clk50M or negedge rst) begin
    if (!rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      big_q <= '0;
      sml_q <= '0;
      r_q <= '0;
      sum_q <= '0;
      fl_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      big_q <= big_d;
      sml_q <= sml_d;
      r_q <= r_d;
      sum_q <= sum_d;
      fl_q <= fl_d;
    end
  end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe: directed vectors, backpressure and reset checks for fp_addsub_pipe
module tb_fp_addsub_pipe;
  logic clk50M = 1'b0;
  logic rst, in_valid, in_ready, sub, out_valid, out_ready;
  logic overflow, underflow, zero, inexact;
  logic [8:0] a, b, sum;
  int checks = 0;
  int errors = 0;
  int idx, k, seen;
  logic rdy, ovs;
  logic [8:0] bp_a [5] = '{9'h078, 9'h070, 9'h071, 9'h080, 9'h1B0};
  logic [8:0] bp_b [5] = '{9'h078, 9'h020, 9'h020, 9'h078, 9'h0A0};
  logic       bp_s [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [8:0] bp_e [5] = '{9'h088, 9'h070, 9'h072, 9'h060, 9'h1A0};
  always #10 clk50M = ~clk50M;
  fp_addsub_pipe dut (
    .clk50M(clk50M), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .overflow(overflow), .underflow(underflow), .zero(zero), .inexact(inexact)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic [8:0] ia, input logic [8:0] ib, input logic is,
                        input logic [8:0] es, input logic [3:0] ef);
    a = ia;
    b = ib;
    sub = is;
    in_valid = 1'b1;
    #1;
    check({tag, ".in_ready"}, in_ready, 1);
    @(posedge clk50M);
    #1 in_valid = 1'b0;
    @(negedge clk50M);
    check({tag, ".lat1"}, out_valid, 0);
    @(negedge clk50M);
    check({tag, ".lat2"}, out_valid, 0);
    @(negedge clk50M);
    check({tag, ".out_valid"}, out_valid, 1);
    check({tag, ".sum"}, sum, es);
    check({tag, ".flags"}, {overflow, underflow, zero, inexact}, ef);
  endtask
  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    sub = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk50M);
    check("rst.out_valid", out_valid, 0);
    check("rst.in_ready", in_ready, 0);
    check("rst.sum", sum, 0);
    check("rst.flags", {overflow, underflow, zero, inexact}, 0);
    rst = 1'b1;
    #1;
    check("rst_release.in_ready", in_ready, 1);
    run_op("add_1p5", 9'h078, 9'h078, 1'b0, 9'h088, 4'b0000);
    run_op("cancel", 9'h078, 9'h078, 1'b1, 9'h000, 4'b0010);
    run_op("tie_even", 9'h070, 9'h020, 1'b0, 9'h070, 4'b0001);
    run_op("tie_odd", 9'h071, 9'h020, 1'b0, 9'h072, 4'b0001);
    run_op("ovf_max", 9'h0FF, 9'h0FF, 1'b0, 9'h0FF, 4'b1000);
    run_op("unf_sub", 9'h011, 9'h010, 1'b1, 9'h000, 4'b0111);
    run_op("zero_pass", 9'h005, 9'h0C4, 1'b1, 9'h1C4, 4'b0000);
    run_op("neg_zeros", 9'h100, 9'h100, 1'b0, 9'h000, 4'b0010);
    run_op("sub_norm", 9'h080, 9'h078, 1'b1, 9'h060, 4'b0000);
    run_op("mixed_sign", 9'h1B0, 9'h0A0, 1'b0, 9'h1A0, 4'b0000);
    run_op("round_bit", 9'h078, 9'h010, 1'b0, 9'h078, 4'b0001);
    run_op("far_sticky", 9'h0F0, 9'h010, 1'b0, 9'h0F0, 4'b0001);
    run_op("rnd_carry", 9'h07F, 9'h020, 1'b0, 9'h080, 4'b0001);
    run_op("rnd_ovf", 9'h0FF, 9'h0A0, 1'b0, 9'h0FF, 4'b1001);
    run_op("unf_edge", 9'h020, 9'h018, 1'b1, 9'h000, 4'b0111);
    run_op("min_norm", 9'h020, 9'h010, 1'b1, 9'h010, 4'b0000);
    @(negedge clk50M);
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      a = bp_a[idx];
      b = bp_b[idx];
      sub = bp_s[idx];
      in_valid = 1'b1;
      #1;
      rdy = in_ready;
      if (c >= 3) check("bp_hold", sum, 9'h088);
      @(posedge clk50M);
      if (rdy) idx++;
      @(negedge clk50M);
    end
    check("bp_accepts", idx, 3);
    check("bp_in_ready", in_ready, 0);
    check("bp_stalled_valid", out_valid, 1);
    out_ready = 1'b1;
    #1;
    check("bp_resume_ready", in_ready, 1);
    k = 0;
    for (int c = 0; c < 12 && k < 5; c++) begin
      in_valid = idx < 5;
      if (idx < 5) begin
        a = bp_a[idx];
        b = bp_b[idx];
        sub = bp_s[idx];
      end
      #1;
      rdy = in_ready;
      ovs = out_valid;
      if (ovs) begin
        check("bp_out", sum, bp_e[k]);
        k++;
      end
      @(posedge clk50M);
      if (in_valid && rdy) idx++;
      @(negedge clk50M);
    end
    in_valid = 1'b0;
    check("bp_results", k, 5);
    check("bp_all_accepted", idx, 5);
    repeat (4) @(negedge clk50M);
    a = 9'h078;
    b = 9'h078;
    sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk50M);
    #1;
    a = 9'h070;
    b = 9'h020;
    @(posedge clk50M);
    #1 in_valid = 1'b0;
    @(negedge clk50M);
    @(negedge clk50M);
    check("rst_pre.out_valid", out_valid, 1);
    rst = 1'b0;
    #1;
    check("rst_mid.out_valid", out_valid, 0);
    check("rst_mid.sum", sum, 0);
    check("rst_mid.in_ready", in_ready, 0);
    @(negedge clk50M);
    rst = 1'b1;
    #1;
    check("rst_after.in_ready", in_ready, 1);
    seen = 0;
    repeat (6) begin
      @(negedge clk50M);
      if (out_valid) seen++;
    end
    check("rst_stale", seen, 0);
    run_op("post_rst", 9'h078, 9'h078, 1'b0, 9'h088, 4'b0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
